tff_toggle_checker: RTL and testbench
=====================================

// Module: tff_toggle_checker
// PURPOSE
//  Synthesizable run-time checker that sits directly downstream of a T flip-flop stage.
//  It samples the stage's t input and q output every clk edge and enforces two rules:
//  - hold:   t==0 at edge k  -> q at edge k+1 == q at edge k
//  - toggle: t==1 at edge k  -> q at edge k+1 == ~(q at edge k)
//  It reports each violation as a one-cycle pulse and keeps sticky flags, saturating counters
//  and the timestamp of the first failure, so checks survive into silicon/FPGA builds.
// PARAMETERS
//  CNT_W   16  width of check/fail counters and cycle timestamp (>=4)
// PORTS
//  clk           in   1      single clock; all sampling on posedge
//  rst           in   1      asynchronous, active-high reset
//  en            in   1      checker enable; 0 discards history
//  clear         in   1      synchronous clear of statistics (sticky, counters, timestamp)
//  t             in   1      T input of monitored flop
//  q             in   1      Q output of monitored flop
//  err_pulse     out  1      1-cycle pulse, registered, on any violation
//  err_type      out  1      valid with err_pulse: 1=toggle rule failed, 0=hold rule failed
//  err_sticky    out  1      set on first violation, held until rst/clear
//  chk_count     out  CNT_W  number of checks performed, saturating
//  tog_fail_cnt  out  CNT_W  toggle-rule failures, saturating
//  hold_fail_cnt out  CNT_W  hold-rule failures, saturating
//  first_err_cyc out  CNT_W  value of cyc counter at first violation; 0 if none
// BEHAVIOUR
//  Reset (async, rst=1): all outputs 0, state=IDLE, history invalid, cyc counter=0.
//  cyc counter: +1 every edge while state!=IDLE, saturates at all-ones, cleared by rst/clear.
//  States:
//   IDLE  : no sampling. en=1 at edge -> capture t_prev<=t, q_prev<=q, go ARMED (no check).
//   ARMED : en=1 at edge -> perform check, recapture t_prev/q_prev, go CHECK.
//           en=0 -> IDLE, history invalid.
//   CHECK : en=1 at edge -> check + recapture, stay. en=0 -> IDLE.
//           ARMED and CHECK are identical except for the debug state encoding.
//  Check at edge k+1: exp = t_prev ? ~q_prev : q_prev; fail = (q != exp).
//   - chk_count += 1.
//   - On fail: err_pulse=1 and err_type=t_prev in the cycle after the edge (1-cycle latency),
//     then the matching fail counter += 1.
//   - On first fail since rst/clear: err_sticky<=1 and first_err_cyc<=cyc.
//   - No fail: err_pulse=0, err_type=0.
//  Counters saturate at 2^CNT_W-1 and never wrap. err_sticky stays set after saturation.
//  clear=1 at edge: sticky, counters and first_err_cyc go to 0; state and history are kept.
//   A check in the same edge still produces err_pulse/err_type, but clear wins for statistics
//   (that fail is not counted).
//  en dropping mid-stream: no check at that edge and err_pulse=0 next cycle.
//   Re-enable requires a new ARMED cycle.
//  rst asserted mid-operation: immediate return to the reset values above, regardless of clk.
//  t/q are sampled synchronously. The block adds no synchronizers; inputs come from the same clk domain.
// TESTING
//  1. rst, then en=1 with samples (t,q) per edge = (1,0),(0,0),(1,1),(0,0),(1,0)
//     -> chk_count=4, tog_fail_cnt=1 (edge2), hold_fail_cnt=1 (edge3),
//        err_sticky=1, first_err_cyc=1.
//  2. Legal stream t=1 for 8 edges, q alternating 0,1,0,...
//     -> chk_count=7, all fail counts 0, err_pulse never 1.
//  3. Hold fail on the same edge as clear=1
//     -> err_pulse=1 with err_type=0 the next cycle; hold_fail_cnt=0, err_sticky=0 afterwards.
//  4. en 1->0->1 with q flipped illegally while en=0
//     -> no violation reported; the first edge after re-enable is ARMED with no check.
//  5. CNT_W=4, t=1 with q held at 0 for 20 edges
//     -> tog_fail_cnt saturates at 15, chk_count=15.
//  6. Assert rst asynchronously between edges while err_sticky=1
//     -> all outputs 0 before the next posedge; state=IDLE.

Source files
------------

// File: rtl/tff_toggle_checker.sv
// Run-time checker for a T flip-flop stage: flags hold/toggle
// rule violations with a pulse, sticky flag, counters and timestamp.
module tff_toggle_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             t,
  input  logic             q,
  output logic             err_pulse,
  output logic             err_type,
  output logic             err_sticky,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] tog_fail_cnt,
  output logic [CNT_W-1:0] hold_fail_cnt,
  output logic [CNT_W-1:0] first_err_cyc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [1:0]       state;
  logic             t_prev;
  logic             q_prev;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] cyc_nxt;
  logic             active;
  logic             do_chk;
  logic             exp_q;
  logic             fail;

  assign active = (state != IDLE);
  assign do_chk = active && en;
  assign exp_q  = t_prev ? ~q_prev : q_prev;
  assign fail   = do_chk && (q != exp_q);

  // Timestamp includes this edge's increment, so a first failure is never 0
  assign cyc_nxt = (active && cyc != MAX) ? cyc + ONE : cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      t_prev <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            t_prev <= t;
            q_prev <= q;
            state  <= ARMED;
          end
        end
        ARMED, CHECK: begin
          if (en) begin
            t_prev <= t;
            q_prev <= q;
            state  <= CHECK;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_type  <= 1'b0;
    end else begin
      err_pulse <= fail;
      err_type  <= fail & t_prev;
    end
  end

  // Clear takes priority over any same-edge statistics update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc           <= '0;
      err_sticky    <= 1'b0;
      chk_count     <= '0;
      tog_fail_cnt  <= '0;
      hold_fail_cnt <= '0;
      first_err_cyc <= '0;
    end else if (clear) begin
      cyc           <= '0;
      err_sticky    <= 1'b0;
      chk_count     <= '0;
      tog_fail_cnt  <= '0;
      hold_fail_cnt <= '0;
      first_err_cyc <= '0;
    end else begin
      cyc <= cyc_nxt;
      if (do_chk && chk_count != MAX)
        chk_count <= chk_count + ONE;
      if (fail) begin
        if (t_prev) begin
          if (tog_fail_cnt != MAX)
            tog_fail_cnt <= tog_fail_cnt + ONE;
        end else begin
          if (hold_fail_cnt != MAX)
            hold_fail_cnt <= hold_fail_cnt + ONE;
        end
        if (!err_sticky) begin
          err_sticky    <= 1'b1;
          first_err_cyc <= cyc_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_tff_toggle_checker.sv
// Directed bench for tff_toggle_checker: default-width instance
// plus a CNT_W=4 instance for saturation.
module tb_tff_toggle_checker;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        en, t, q;
  logic        en4, t4, q4;

  logic        err_pulse, err_type, err_sticky;
  logic [15:0] chk_count, tog_fail_cnt, hold_fail_cnt, first_err_cyc;

  logic        p4, ty4, st4;
  logic [3:0]  chk4, tog4, hold4, first4;

  int n_cmp = 0;
  int n_bad = 0;

  tff_toggle_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .t(t), .q(q),
    .err_pulse(err_pulse), .err_type(err_type),
    .err_sticky(err_sticky), .chk_count(chk_count),
    .tog_fail_cnt(tog_fail_cnt), .hold_fail_cnt(hold_fail_cnt),
    .first_err_cyc(first_err_cyc)
  );

  tff_toggle_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .clear(clear),
    .t(t4), .q(q4),
    .err_pulse(p4), .err_type(ty4),
    .err_sticky(st4), .chk_count(chk4),
    .tog_fail_cnt(tog4), .hold_fail_cnt(hold4),
    .first_err_cyc(first4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample, clock it, and land 1 time unit after the edge
  task automatic step(input logic e, input logic tt, input logic qq);
    en = e; t = tt; q = qq;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    en = 1'b0; t = 1'b0; q = 1'b0;
    en4 = 1'b0; t4 = 1'b0; q4 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({err_pulse, err_type, err_sticky} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000",
               {err_pulse, err_type, err_sticky});
    end
    n_cmp++;
    if ({chk_count, tog_fail_cnt, hold_fail_cnt, first_err_cyc} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_cnts got %h want 0",
               {chk_count, tog_fail_cnt, hold_fail_cnt, first_err_cyc});
    end
    rst = 1'b0;
  endtask

  task automatic test_mixed_stream();
    logic [4:0] tv, qv, pv, yv;
    tv = 5'b10101; qv = 5'b00100;
    pv = 5'b01100; yv = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, tv[4-i], qv[4-i]);
      n_cmp++;
      if (err_pulse !== pv[4-i] || err_type !== yv[4-i]) begin
        n_bad++;
        $display("FAIL mixed_pulse edge%0d got %b%b want %b%b",
                 i + 1, err_pulse, err_type, pv[4-i], yv[4-i]);
      end
    end
    n_cmp++;
    if (chk_count !== 16'd4) begin
      n_bad++; $display("FAIL mixed_chk got %0d want 4", chk_count);
    end
    n_cmp++;
    if (tog_fail_cnt !== 16'd1 || hold_fail_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL mixed_fails got %0d/%0d want 1/1",
               tog_fail_cnt, hold_fail_cnt);
    end
    n_cmp++;
    if (err_sticky !== 1'b1 || first_err_cyc !== 16'd1) begin
      n_bad++;
      $display("FAIL mixed_first got %b/%0d want 1/1",
               err_sticky, first_err_cyc);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_legal_stream();
    int pulses;
    pulses = 0;
    clear = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    n_cmp++;
    if (err_sticky !== 1'b0 || chk_count !== 16'd0 || first_err_cyc !== 16'd0) begin
      n_bad++;
      $display("FAIL clear_stats got %b/%0d/%0d want 0/0/0",
               err_sticky, chk_count, first_err_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'(i % 2));
      if (err_pulse !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL legal_pulses got %0d want 0", pulses);
    end
    n_cmp++;
    if (chk_count !== 16'd7) begin
      n_bad++; $display("FAIL legal_chk got %0d want 7", chk_count);
    end
    n_cmp++;
    if (tog_fail_cnt !== 16'd0 || hold_fail_cnt !== 16'd0 || err_sticky !== 1'b0) begin
      n_bad++;
      $display("FAIL legal_fails got %0d/%0d/%b want 0/0/0",
               tog_fail_cnt, hold_fail_cnt, err_sticky);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear_same_edge();
    step(1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    clear = 1'b0;
    n_cmp++;
    if (err_pulse !== 1'b1 || err_type !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_pulse got %b%b want 10", err_pulse, err_type);
    end
    n_cmp++;
    if (hold_fail_cnt !== 16'd0 || err_sticky !== 1'b0 || chk_count !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_stats got %0d/%b/%0d want 0/0/0",
               hold_fail_cnt, err_sticky, chk_count);
    end
  endtask

  task automatic test_reenable();
    int pulses;
    pulses = 0;
    step(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (chk_count !== 16'd1 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL reen_pre got %0d/%b want 1/0", chk_count, err_pulse);
    end
    step(1'b0, 1'b0, 1'b1);
    if (err_pulse !== 1'b0) pulses++;
    step(1'b0, 1'b0, 1'b0);
    if (err_pulse !== 1'b0) pulses++;
    step(1'b1, 1'b1, 1'b0);
    if (err_pulse !== 1'b0) pulses++;
    n_cmp++;
    if (chk_count !== 16'd1) begin
      n_bad++; $display("FAIL reen_armed got %0d want 1", chk_count);
    end
    step(1'b1, 1'b0, 1'b1);
    if (err_pulse !== 1'b0) pulses++;
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL reen_pulses got %0d want 0", pulses);
    end
    n_cmp++;
    if (chk_count !== 16'd2 || err_sticky !== 1'b0 ||
        tog_fail_cnt !== 16'd0 || hold_fail_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reen_stats got %0d/%b/%0d/%0d want 2/0/0/0",
               chk_count, err_sticky, tog_fail_cnt, hold_fail_cnt);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    en4 = 1'b1; t4 = 1'b1; q4 = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    en4 = 1'b0;
    n_cmp++;
    if (tog4 !== 4'd15 || chk4 !== 4'd15 || hold4 !== 4'd0) begin
      n_bad++;
      $display("FAIL sat_cnts got %0d/%0d/%0d want 15/15/0",
               tog4, chk4, hold4);
    end
    n_cmp++;
    if (p4 !== 1'b1 || ty4 !== 1'b1 || st4 !== 1'b1 || first4 !== 4'd1) begin
      n_bad++;
      $display("FAIL sat_flags got %b%b%b/%0d want 111/1",
               p4, ty4, st4, first4);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (err_sticky !== 1'b1 || err_pulse !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_pre got %b%b want 11", err_sticky, err_pulse);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({err_pulse, err_type, err_sticky, chk_count,
         tog_fail_cnt, hold_fail_cnt, first_err_cyc} !== 67'd0) begin
      n_bad++;
      $display("FAIL arst_dut got %b%b%b/%0d/%0d/%0d/%0d want all 0",
               err_pulse, err_type, err_sticky, chk_count,
               tog_fail_cnt, hold_fail_cnt, first_err_cyc);
    end
    n_cmp++;
    if ({p4, ty4, st4, chk4, tog4, hold4, first4} !== 19'd0) begin
      n_bad++;
      $display("FAIL arst_dut4 got %b%b%b/%0d/%0d want all 0",
               p4, ty4, st4, chk4, tog4);
    end
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (chk_count !== 16'd0 || err_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_idle got %0d/%b want 0/0", chk_count, err_pulse);
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (chk_count !== 16'd1 || err_pulse !== 1'b1 || err_type !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_armed got %0d/%b%b want 1/11",
               chk_count, err_pulse, err_type);
    end
  endtask

  initial begin
    test_reset();
    test_mixed_stream();
    test_legal_stream();
    test_clear_same_edge();
    test_reenable();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
